optics_array: RTL and testbench



---
 rtl/optics_pkg.sv | 19 +
 rtl/optics_debounce.sv | 66 ++++++
 rtl/optics_array.sv | 87 ++++++++
 tb/tb_optics_array.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/optics_pkg.sv
// Shared types and helpers for the optics_array proximity conditioner.
// Optional hit counters are controlled by the OPTICS_HIT_CNT_EN macro (see optics_array).
package optics_pkg;

   // Idle value of the aggregate "any near" flag (no channel reports an object)
   localparam logic ANY_NEAR_IDLE = 1'b0;

   // Accepted (debounced) level of one sensor channel
   typedef enum logic {
      ST_FAR  = 1'b0,
      ST_NEAR = 1'b1
   } prox_state_e;

   // Width of the debounce counter: wide enough to hold DEBOUNCE_CYCLES-1 with headroom
   function automatic int dcWidth(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/optics_debounce.sv
// One proximity channel: input synchroniser, debounce filter and registered edge pulses.
// prox_d_o exposes the next debounced value so the parent can register aggregates on the same edge.
module optics_debounce
   import optics_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic prox_o,
   output logic prox_d_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int DC_W = dcWidth(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DC_W-1:0]        dc_q, dc_d;
   prox_state_e            state_q, state_d;
   logic                   rise_q, fall_q;
   logic                   syncBit;
   logic                   stableBit;

   assign syncBit   = sync_q[SYNC_STAGES-1];
   assign stableBit = (state_q == ST_NEAR);

   // Accept a new level only after DEBOUNCE_CYCLES consecutive samples disagree with the stable one
   always_comb begin
      state_d = state_q;
      dc_d    = dc_q;
      if (syncBit == stableBit) begin
         dc_d = '0;
      end else if (dc_q == DC_W'(DEBOUNCE_CYCLES - 1)) begin
         state_d = syncBit ? ST_NEAR : ST_FAR;
         dc_d    = '0;
      end else begin
         dc_d = dc_q + 1'b1;
      end
   end

   // Synchroniser shift, filter state and edge pulses aligned with the first cycle of the new level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         dc_q    <= '0;
         state_q <= ST_FAR;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
         dc_q    <= dc_d;
         state_q <= state_d;
         rise_q  <= (state_d == ST_NEAR) && (state_q == ST_FAR);
         fall_q  <= (state_d == ST_FAR) && (state_q == ST_NEAR);
      end
   end

   assign prox_o   = (state_q == ST_NEAR);
   assign prox_d_o = (state_d == ST_NEAR);
   assign rise_o   = rise_q;
   assign fall_o   = fall_q;

endmodule

// File: rtl/optics_array.sv
// N_CH-channel infrared proximity conditioner for the Fish level finder.
// Define OPTICS_HIT_CNT_EN to build the per-channel saturating rise counters;
// otherwise hit_count is tied to zero and clr_count is ignored.
module optics_array
   import optics_pkg::*;
#(
   parameter int N_CH            = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_CH-1:0]       proximity_out,
   input  logic                  clr_count,
   output logic [N_CH-1:0]       proximity,
   output logic [N_CH-1:0]       prox_rise,
   output logic [N_CH-1:0]       prox_fall,
   output logic                  any_near,
   output logic [N_CH-1:0]       led,
   output logic [N_CH*CNT_W-1:0] hit_count
);

   logic [N_CH-1:0] proxNext;
   logic [N_CH-1:0] proxCur;
   logic [N_CH-1:0] riseCur;
   logic [N_CH-1:0] fallCur;
   logic [N_CH-1:0] led_q;
   logic            anyNear_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      optics_debounce #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .reset   (reset),
         .raw_i   (proximity_out[i]),
         .prox_o  (proxCur[i]),
         .prox_d_o(proxNext[i]),
         .rise_o  (riseCur[i]),
         .fall_o  (fallCur[i])
      );
   end

   // LED mirror lags proximity by a cycle; any_near follows proximity on the same edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q     <= '0;
         anyNear_q <= ANY_NEAR_IDLE;
      end else begin
         led_q     <= proxCur;
         anyNear_q <= |proxNext;
      end
   end

`ifdef OPTICS_HIT_CNT_EN
   logic [CNT_W-1:0] cnt_q [N_CH];

   for (genvar i = 0; i < N_CH; i++) begin : g_cnt
      // Count rise pulses, saturating at all-ones; a clear wins over a same-cycle increment
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_q[i] <= '0;
         end else if (clr_count) begin
            cnt_q[i] <= '0;
         end else if (riseCur[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end

      assign hit_count[i*CNT_W +: CNT_W] = cnt_q[i];
   end
`else
   logic unusedClr;

   assign unusedClr = clr_count;
   assign hit_count = '0;
`endif

   assign proximity = proxCur;
   assign prox_rise = riseCur;
   assign prox_fall = fallCur;
   assign led       = led_q;
   assign any_near  = anyNear_q;

endmodule

// File: tb/tb_optics_array.sv
// Self-checking bench for optics_array: directed scenarios plus random channel activity,
// compared every cycle against a behavioural run-length model of the filter.
module tb_optics_array;

   localparam int N_CH            = 4;
   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int CNT_W           = 2;
   localparam int CNT_MAX         = (1 << CNT_W) - 1;
`ifdef OPTICS_HIT_CNT_EN
   localparam bit HIT_EN = 1'b1;
`else
   localparam bit HIT_EN = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [N_CH-1:0]       proximity_out = '0;
   logic                  clr_count = 1'b0;
   logic [N_CH-1:0]       proximity;
   logic [N_CH-1:0]       prox_rise;
   logic [N_CH-1:0]       prox_fall;
   logic                  any_near;
   logic [N_CH-1:0]       led;
   logic [N_CH*CNT_W-1:0] hit_count;

   int testsRun = 0;
   int testsFailed = 0;

   // Behavioural model state
   logic [N_CH-1:0] syncQ[$];
   logic [N_CH-1:0] mProx, mRise, mFall, mLed;
   logic            mAny;
   int              mRun[N_CH];
   int              mCnt[N_CH];

   // Scenario scratch
   logic [N_CH-1:0] rawVec;
   logic [N_CH-1:0] firstFall;
   bit              seen;

   always #5 clk = ~clk;

   optics_array #(
      .N_CH           (N_CH),
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .proximity_out(proximity_out),
      .clr_count    (clr_count),
      .proximity    (proximity),
      .prox_rise    (prox_rise),
      .prox_fall    (prox_fall),
      .any_near     (any_near),
      .led          (led),
      .hit_count    (hit_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      syncQ.delete();
      for (int k = 0; k < SYNC_STAGES; k++) syncQ.push_back('0);
      mProx = '0; mRise = '0; mFall = '0; mLed = '0; mAny = 1'b0;
      for (int ch = 0; ch < N_CH; ch++) begin
         mRun[ch] = 0;
         mCnt[ch] = 0;
      end
   endtask

   // One rising edge: raw input reaches the filter SYNC_STAGES edges after it is sampled;
   // a level is accepted after DEBOUNCE_CYCLES consecutive disagreeing samples
   task automatic modelEdge(input logic [N_CH-1:0] raw, input logic clr);
      logic [N_CH-1:0] s, newProx;
      s = syncQ.pop_front();
      syncQ.push_back(raw);
      for (int ch = 0; ch < N_CH; ch++) begin
         if (clr) mCnt[ch] = 0;
         else if (mRise[ch] && mCnt[ch] < CNT_MAX) mCnt[ch] = mCnt[ch] + 1;
      end
      newProx = mProx;
      for (int ch = 0; ch < N_CH; ch++) begin
         if (s[ch] != mProx[ch]) begin
            mRun[ch] = mRun[ch] + 1;
            if (mRun[ch] >= DEBOUNCE_CYCLES) begin
               newProx[ch] = s[ch];
               mRun[ch] = 0;
            end
         end else begin
            mRun[ch] = 0;
         end
      end
      mRise = newProx & ~mProx;
      mFall = mProx & ~newProx;
      mLed  = mProx;
      mAny  = |newProx;
      mProx = newProx;
   endtask

   function automatic logic [N_CH*CNT_W-1:0] expHit();
      logic [N_CH*CNT_W-1:0] v;
      v = '0;
      if (HIT_EN)
         for (int ch = 0; ch < N_CH; ch++) v[ch*CNT_W +: CNT_W] = CNT_W'(mCnt[ch]);
      return v;
   endfunction

   task automatic checkOutput();
      check("proximity", 32'(proximity), 32'(mProx));
      check("prox_rise", 32'(prox_rise), 32'(mRise));
      check("prox_fall", 32'(prox_fall), 32'(mFall));
      check("any_near",  32'(any_near),  32'(mAny));
      check("led",       32'(led),       32'(mLed));
      check("hit_count", 32'(hit_count), 32'(expHit()));
   endtask

   // Called at a falling edge: drive inputs, advance one clock, check at the next falling edge
   task automatic applyStimulus(input logic [N_CH-1:0] raw, input logic clr);
      proximity_out = raw;
      clr_count     = clr;
      @(posedge clk);
      modelEdge(raw, clr);
      @(negedge clk);
      checkOutput();
   endtask

   // Asynchronous reset pulse placed mid-cycle; outputs must clear before any clock edge
   task automatic doReset();
      #2;
      reset = 1'b1;
      #1;
      check("rstProximity", 32'(proximity), 32'd0);
      check("rstRise",      32'(prox_rise), 32'd0);
      check("rstFall",      32'(prox_fall), 32'd0);
      check("rstAnyNear",   32'(any_near),  32'd0);
      check("rstLed",       32'(led),       32'd0);
      check("rstHitCount",  32'(hit_count), 32'd0);
      modelReset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      modelReset();
      #1;
      check("initProximity", 32'(proximity), 32'd0);
      check("initHitCount",  32'(hit_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Latency: ch1 high before edge 1
      for (int k = 1; k <= 9; k++) begin
         applyStimulus(4'b0010, 1'b0);
         check("latProx1",   32'(proximity[1]), 32'(k >= 6));
         check("latRise1",   32'(prox_rise[1]), 32'(k == 6));
         check("latLed1",    32'(led[1]),       32'(k >= 7));
         check("latAnyNear", 32'(any_near),     32'(k >= 6));
      end

      // Async reset while outputs are active, then reset in the middle of a ch0 filter run
      doReset();
      for (int k = 0; k < 3; k++) applyStimulus(4'b0001, 1'b0);
      doReset();
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(4'b0001, 1'b0);
         check("rstFiltProx0", 32'(proximity[0]), 32'(k >= 6));
         check("rstFiltRise0", 32'(prox_rise[0]), 32'(k == 6));
      end
      for (int k = 0; k < 8; k++) applyStimulus(4'b0000, 1'b0);

      // Glitch rejection on ch2: three samples rejected, four accepted
      for (int k = 0; k < 3; k++) applyStimulus(4'b0100, 1'b0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(4'b0000, 1'b0);
         check("glitchProx2", 32'(proximity[2]), 32'd0);
      end
      for (int k = 0; k < 4; k++) applyStimulus(4'b0100, 1'b0);
      for (int k = 0; k < 6; k++) applyStimulus(4'b0000, 1'b0);
      check("glitchAccepted2", 32'(led[2] | proximity[2]), 32'd1);
      for (int k = 0; k < 8; k++) applyStimulus(4'b0000, 1'b0);

      // Simultaneous fall on ch0 and ch3 while ch1 keeps any_near high
      for (int k = 0; k < 10; k++) applyStimulus(4'b1011, 1'b0);
      seen = 1'b0;
      firstFall = '0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(4'b0010, 1'b0);
         if (!seen && prox_fall != '0) begin
            seen = 1'b1;
            firstFall = prox_fall;
         end
      end
      check("simulFall",    32'(firstFall), 32'(4'b1001));
      check("simulAnyNear", 32'(any_near),  32'd1);
      for (int k = 0; k < 10; k++) applyStimulus(4'b0000, 1'b0);
      check("lastClearAny", 32'(any_near),  32'd0);

      // Counter saturation: five rises on ch0
      doReset();
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 6; k++) applyStimulus(4'b0001, 1'b0);
         for (int k = 0; k < 6; k++) applyStimulus(4'b0000, 1'b0);
         check("satCount0", 32'(hit_count[CNT_W-1:0]),
               HIT_EN ? 32'((r + 1 < CNT_MAX) ? r + 1 : CNT_MAX) : 32'd0);
      end

      // Clear arriving together with a rise pulse wins
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         applyStimulus(4'b0001, 1'b0);
         seen = prox_rise[0];
      end
      check("clrRiseSeen", 32'(seen), 32'd1);
      applyStimulus(4'b0001, 1'b1);
      check("clrWithRise", 32'(hit_count[CNT_W-1:0]), 32'd0);
      for (int k = 0; k < 8; k++) applyStimulus(4'b0000, 1'b0);

      // Random activity on all channels with occasional clears and one mid-run reset
      rawVec = '0;
      for (int n = 0; n < 500; n++) begin
         for (int ch = 0; ch < N_CH; ch++)
            if ($urandom_range(0, 5) == 0) rawVec[ch] = ~rawVec[ch];
         if (n == 250) doReset();
         applyStimulus(rawVec, ($urandom_range(0, 39) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
